tx_packet_scheduler: RTL and testbench
======================================

TX_PACKET_SCHEDULER -- requirements
Module: tx_packet_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 12, meaning idle cycles enforced after each packet.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning maximum WAIT cycles before abort (used only with TX_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port i_req, input, 2, one-cycle send requests: bit0 ARP, bit1 UDP (same encoding as the command send pulse).
REQ-006 SHALL have port i_udp_period, input, 16, auto-UDP interval in cycles; 0 disables.
REQ-007 SHALL have port i_tx_done, input, 1, one-cycle pulse from the packet builder at end of frame.
REQ-008 SHALL have port o_start, output, 1, one-cycle start pulse to the packet builder.
REQ-009 SHALL have port o_sel, output, 2, granted packet type (01 ARP, 10 UDP), 00 when idle.
REQ-010 SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port o_pend, output, 2, pending request flags.
REQ-012 SHALL have port o_drop_cnt, output, 8, count of requests merged into an already-set pending flag.
REQ-013 SHALL have port o_timeout, output, 1, one-cycle abort pulse.

Function
REQ-014 SHALL latch i_req bit k (or auto-UDP tick for bit1) into pend[k] on the next clock edge.
REQ-015 SHALL give set priority over clear when a request and a grant of the same bit coincide; the flag stays 1.
REQ-016 SHALL increment o_drop_cnt when a request hits an already-set flag that is not being cleared that cycle; saturates at 255; both bits in one cycle count as 2.
REQ-017 SHALL run a 16-bit period counter 0..i_udp_period-1, issuing a UDP tick when counter equals i_udp_period-1; counter held at 0 when period is 0; counter resets to 0 if it is >= i_udp_period.
REQ-018 SHALL implement states IDLE, START, WAIT, GAP.
REQ-019 IDLE: if o_pend != 0, choose grant, clear that pend bit, go START next cycle.
REQ-020 SHALL arbitrate round-robin: both pending -> grant the type not granted last; single pending -> grant it; last-grant resets to UDP so ARP wins the first tie.
REQ-021 START: o_start=1 for exactly this one cycle, o_sel valid; go WAIT.
REQ-022 WAIT: o_sel held; on i_tx_done go GAP; i_tx_done in any other state SHALL be ignored.
REQ-023 GAP: o_sel=00; count GAP_CYCLES cycles then IDLE; GAP_CYCLES=0 returns to IDLE on the next cycle.
REQ-024 Minimum spacing: i_tx_done to next o_start SHALL be GAP_CYCLES+3 cycles (GAP, IDLE, START).

Reset
REQ-025 On rst_n low SHALL asynchronously enter IDLE with o_start=0, o_sel=00, o_busy=0, o_pend=00, o_drop_cnt=0, o_timeout=0, period counter 0, last-grant UDP.
REQ-026 Reset mid-WAIT SHALL discard the grant; a following i_tx_done SHALL be ignored.

Configuration
REQ-027 With TX_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT_CYCLES without i_tx_done SHALL pulse o_timeout one cycle and go GAP.
REQ-028 Without TX_TIMEOUT_EN: WAIT waits indefinitely; o_timeout tied 0; no timeout counter synthesized.

Verification
REQ-029 i_req=01 at cycle 0 -> pend=01 at 1, o_start with o_sel=01 at cycle 3, o_busy high from 2.
REQ-030 i_req=11 at cycle 0 -> ARP granted first; after done+GAP(12) UDP started exactly 15 cycles after done.
REQ-031 i_req=10 three times while UDP pending -> o_drop_cnt=2, one UDP packet sent.
REQ-032 i_udp_period=100, no other requests, done returned 10 cycles after each start -> one UDP start per 100 cycles.
REQ-033 TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done -> o_timeout pulse 16 cycles into WAIT, back to IDLE after gap.
REQ-034 rst_n low during WAIT then i_tx_done after release -> stays IDLE, o_start not asserted.

Source files
------------

// File: rtl/tx_packet_scheduler.sv
// TX packet scheduler: round-robin ARP/UDP arbitration, auto-UDP period tick, inter-packet gap.
// Optional WAIT abort when the macro TX_TIMEOUT_EN is defined.
module tx_packet_scheduler #(
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_udp_period,
  input  logic        i_tx_done,
  output logic        o_start,
  output logic [1:0]  o_sel,
  output logic        o_busy,
  output logic [1:0]  o_pend,
  output logic [7:0]  o_drop_cnt,
  output logic        o_timeout
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  if (GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("tx_packet_scheduler: GAP_CYCLES must be >= 0 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t          state;
  logic [1:0]      pend;
  logic [1:0]      req_set;
  logic [1:0]      grant;
  logic [1:0]      drop_hit;
  logic [1:0]      drop_inc;
  logic [8:0]      drop_sum;
  logic            last_grant_udp;
  logic [15:0]     per_cnt;
  logic            udp_tick;
  logic [GW-1:0]   gap_cnt;

  assign udp_tick = (i_udp_period != 16'd0) && (per_cnt == i_udp_period - 16'd1);
  assign req_set  = i_req | {udp_tick, 1'b0};

  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (pend)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_udp ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // A request landing on a flag that is being granted this cycle is not a drop.
  assign drop_hit = req_set & pend & ~grant;
  assign drop_inc = {1'b0, drop_hit[0]} + {1'b0, drop_hit[1]};
  assign drop_sum = {1'b0, o_drop_cnt} + {7'b0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 2'b00;
      o_drop_cnt <= 8'd0;
      per_cnt    <= 16'd0;
    end else begin
      pend       <= (pend & ~grant) | req_set;
      o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (i_udp_period == 16'd0 || per_cnt >= i_udp_period - 16'd1)
        per_cnt <= 16'd0;
      else
        per_cnt <= per_cnt + 16'd1;
    end
  end

  assign o_pend = pend;
  assign o_busy = (state != IDLE);

`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      o_sel          <= 2'b00;
      o_start        <= 1'b0;
      last_grant_udp <= 1'b1;
      gap_cnt        <= '0;
`ifdef TX_TIMEOUT_EN
      to_cnt         <= '0;
      o_timeout      <= 1'b0;
`endif
    end else begin
      o_start <= 1'b0;
`ifdef TX_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            o_sel          <= grant;
            last_grant_udp <= grant[1];
            state          <= START;
          end
        end
        START: begin
          o_start <= 1'b1;
          state   <= WAIT;
`ifdef TX_TIMEOUT_EN
          to_cnt  <= TW'(TIMEOUT_CYCLES);
`endif
        end
        WAIT: begin
          if (i_tx_done) begin
            o_sel   <= 2'b00;
            gap_cnt <= GW'(GAP_CYCLES);
            state   <= GAP;
          end
`ifdef TX_TIMEOUT_EN
          else if (to_cnt <= TW'(1)) begin
            o_sel     <= 2'b00;
            gap_cnt   <= GW'(GAP_CYCLES);
            o_timeout <= 1'b1;
            state     <= GAP;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
`endif
        end
        GAP: begin
          // Terminal count at 1 gives exactly GAP_CYCLES cycles; 0 still spends one.
          if (gap_cnt <= GW'(1))
            state <= IDLE;
          else
            gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Scoreboard bench for tx_packet_scheduler: expected grants queued at request time, popped on o_start.
module tb_tx_packet_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  i_req;
  logic [15:0] i_udp_period;
  logic        i_tx_done;
  logic        o_start;
  logic [1:0]  o_sel;
  logic        o_busy;
  logic [1:0]  o_pend;
  logic [7:0]  o_drop_cnt;
  logic        o_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_sel;

  tx_packet_scheduler #(.GAP_CYCLES(12), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_udp_period(i_udp_period),
    .i_tx_done(i_tx_done), .o_start(o_start), .o_sel(o_sel), .o_busy(o_busy),
    .o_pend(o_pend), .o_drop_cnt(o_drop_cnt), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    i_req = 2'b00;
    i_tx_done = 1'b0;
    i_udp_period = 16'd0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int budget, output int waited);
    waited = 0;
    while (o_start !== 1'b1 && waited < budget) begin
      step();
      waited++;
    end
    if (o_start !== 1'b1) waited = -1;
  endtask

  task automatic pulse_done();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 2'b00;
    i_tx_done = 1'b0;
    i_udp_period = 16'd0;
    #1;
    n_checks++;
    if (o_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", o_start); end
    n_checks++;
    if (o_sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b expected 00", o_sel); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++;
    if (o_pend !== 2'b00) begin n_fail++; $display("FAIL reset_pend: got %b expected 00", o_pend); end
    n_checks++;
    if (o_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", o_drop_cnt); end
    n_checks++;
    if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", o_timeout); end
    apply_reset();
    repeat (3) step();
    n_checks++;
    if (o_busy !== 1'b0 || o_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_after: busy %b start %b expected 0 0", o_busy, o_start);
    end
  endtask

  task automatic test_single_arp();
    int n;
    apply_reset();
    i_req = 2'b01; exp_q.push_back(2'b01);
    step();
    i_req = 2'b00;
    n_checks++;
    if (o_pend !== 2'b01 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL arp_cycle1: pend %b busy %b expected 01 0", o_pend, o_busy);
    end
    step();
    n_checks++;
    if (o_busy !== 1'b1 || o_start !== 1'b0 || o_pend !== 2'b00) begin
      n_fail++; $display("FAIL arp_cycle2: busy %b start %b pend %b expected 1 0 00", o_busy, o_start, o_pend);
    end
    step();
    exp_sel = exp_q.pop_front();
    n_checks++;
    if (o_start !== 1'b1 || o_sel !== exp_sel) begin
      n_fail++; $display("FAIL arp_cycle3: start %b sel %b expected 1 %b", o_start, o_sel, exp_sel);
    end
    step();
    n_checks++;
    if (o_start !== 1'b0 || o_sel !== 2'b01) begin
      n_fail++; $display("FAIL arp_wait: start %b sel %b expected 0 01", o_start, o_sel);
    end
    pulse_done();
    n_checks++;
    if (o_sel !== 2'b00 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL arp_gap: sel %b busy %b expected 00 1", o_sel, o_busy);
    end
    n = 0;
    while (o_busy === 1'b1 && n < 50) begin step(); n++; end
    n_checks++;
    if (n + 1 != 13) begin
      n_fail++; $display("FAIL arp_gap_len: done-to-idle %0d cycles expected 13", n + 1);
    end
  endtask

  task automatic test_tie();
    int w;
    apply_reset();
    i_req = 2'b11; exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    step();
    i_req = 2'b00;
    wait_start(10, w);
    exp_sel = exp_q.pop_front();
    n_checks++;
    if (w < 0 || o_sel !== exp_sel) begin
      n_fail++; $display("FAIL tie_first: waited %0d sel %b expected %b", w, o_sel, exp_sel);
    end
    n_checks++;
    if (o_pend !== 2'b10) begin n_fail++; $display("FAIL tie_pend: got %b expected 10", o_pend); end
    pulse_done();
    wait_start(40, w);
    exp_sel = exp_q.pop_front();
    n_checks++;
    if (w < 0 || w + 1 != 15 || o_sel !== exp_sel) begin
      n_fail++; $display("FAIL tie_second: spacing %0d sel %b expected 15 %b", w + 1, o_sel, exp_sel);
    end
    pulse_done();
  endtask

  task automatic test_set_priority();
    int w;
    apply_reset();
    i_req = 2'b10; exp_q.push_back(2'b10);
    step();
    i_req = 2'b10; exp_q.push_back(2'b10);
    step();
    i_req = 2'b00;
    n_checks++;
    if (o_pend !== 2'b10 || o_drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL setprio: pend %b drop %0d expected 10 0", o_pend, o_drop_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      wait_start(40, w);
      exp_sel = exp_q.pop_front();
      n_checks++;
      if (w < 0 || o_sel !== exp_sel) begin
        n_fail++; $display("FAIL setprio_pkt%0d: waited %0d sel %b expected %b", k, w, o_sel, exp_sel);
      end
      step();
      pulse_done();
    end
  endtask

  task automatic test_drop();
    int w;
    int starts;
    apply_reset();
    i_req = 2'b01; exp_q.push_back(2'b01);
    step();
    i_req = 2'b00;
    wait_start(10, w);
    exp_sel = exp_q.pop_front();
    n_checks++;
    if (w < 0 || o_sel !== exp_sel) begin
      n_fail++; $display("FAIL drop_first: waited %0d sel %b expected %b", w, o_sel, exp_sel);
    end
    i_req = 2'b10; exp_q.push_back(2'b10);
    step(); step(); step();
    i_req = 2'b01; exp_q.push_back(2'b01);
    step();
    i_req = 2'b11;
    step();
    i_req = 2'b00;
    n_checks++;
    if (o_drop_cnt !== 8'd4 || o_pend !== 2'b11) begin
      n_fail++; $display("FAIL drop_count: drop %0d pend %b expected 4 11", o_drop_cnt, o_pend);
    end
    pulse_done();
    for (int k = 0; k < 2; k++) begin
      wait_start(40, w);
      exp_sel = exp_q.pop_front();
      n_checks++;
      if (w < 0 || o_sel !== exp_sel) begin
        n_fail++; $display("FAIL drop_pkt%0d: waited %0d sel %b expected %b", k, w, o_sel, exp_sel);
      end
      step();
      pulse_done();
    end
    starts = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_start === 1'b1) starts++;
    end
    n_checks++;
    if (starts != 0 || exp_q.size() != 0 || o_pend !== 2'b00 || o_drop_cnt !== 8'd4) begin
      n_fail++; $display("FAIL drop_drain: extra starts %0d left %0d pend %b drop %0d expected 0 0 00 4",
                         starts, exp_q.size(), o_pend, o_drop_cnt);
    end
  endtask

  task automatic test_drop_saturate();
    int w;
    apply_reset();
    i_req = 2'b01;
    step();
    i_req = 2'b00;
    wait_start(10, w);
    i_req = 2'b11;
    for (int k = 0; k < 131; k++) step();
    i_req = 2'b00;
    n_checks++;
    if (w < 0 || o_drop_cnt !== 8'd255) begin
      n_fail++; $display("FAIL drop_sat: waited %0d drop %0d expected 255", w, o_drop_cnt);
    end
  endtask

  task automatic test_auto_udp();
    int exp_cyc[$];
    int done_at;
    int starts;
    int ec;
    apply_reset();
    done_at = -1;
    starts = 0;
    for (int c = 0; c <= 360; c++) begin
      if (c == 0) i_udp_period = 16'd100;
      if (o_start === 1'b1) begin
        starts++;
        n_checks++;
        if (exp_q.size() == 0 || exp_cyc.size() == 0) begin
          n_fail++; $display("FAIL auto_unexpected: start at cycle %0d expected none", c);
        end else begin
          exp_sel = exp_q.pop_front();
          ec = exp_cyc.pop_front();
          if (o_sel !== exp_sel || c != ec) begin
            n_fail++; $display("FAIL auto_start: cycle %0d sel %b expected cycle %0d sel %b", c, o_sel, ec, exp_sel);
          end
        end
        done_at = c + 10;
      end
      i_tx_done = (c == done_at);
      if (c % 100 == 99) begin
        exp_q.push_back(2'b10);
        exp_cyc.push_back(c + 3);
      end
      step();
    end
    i_tx_done = 1'b0;
    i_udp_period = 16'd0;
    n_checks++;
    if (starts != 3 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL auto_count: starts %0d left %0d expected 3 0", starts, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    int starts;
    apply_reset();
    i_req = 2'b10;
    step();
    i_req = 2'b00;
    wait_start(10, w);
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_sel !== 2'b00) begin
      n_fail++; $display("FAIL rstwait_async: busy %b sel %b expected 0 00", o_busy, o_sel);
    end
    step();
    rst_n = 1'b1;
    pulse_done();
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_start === 1'b1 || o_busy === 1'b1) starts++;
      step();
    end
    n_checks++;
    if (w < 0 || starts != 0) begin
      n_fail++; $display("FAIL rstwait_idle: waited %0d active cycles %0d expected 0", w, starts);
    end
  endtask

  task automatic test_timeout();
    int w;
    int n;
    apply_reset();
    i_req = 2'b01;
    step();
    i_req = 2'b00;
    wait_start(10, w);
`ifdef TX_TIMEOUT_EN
    n = 0;
    while (o_timeout !== 1'b1 && n < 40) begin step(); n++; end
    n_checks++;
    if (w < 0 || n != 16) begin
      n_fail++; $display("FAIL timeout_at: %0d cycles into WAIT expected 16", n);
    end
    step();
    n_checks++;
    if (o_timeout !== 1'b0 || o_sel !== 2'b00 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL timeout_pulse: to %b sel %b busy %b expected 0 00 1", o_timeout, o_sel, o_busy);
    end
    n = 1;
    while (o_busy === 1'b1 && n < 40) begin step(); n++; end
    n_checks++;
    if (n != 12) begin
      n_fail++; $display("FAIL timeout_gap: %0d cycles to idle expected 12", n);
    end
`else
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_timeout !== 1'b0) n++;
    end
    n_checks++;
    if (w < 0 || n != 0 || o_busy !== 1'b1 || o_sel !== 2'b01) begin
      n_fail++; $display("FAIL wait_forever: to-cycles %0d busy %b sel %b expected 0 1 01", n, o_busy, o_sel);
    end
    pulse_done();
`endif
  endtask

  initial begin
    test_reset();
    test_single_arp();
    test_tie();
    test_set_priority();
    test_drop();
    test_drop_saturate();
    test_auto_udp();
    test_reset_mid_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
